// File: rtl/screen_scanner.sv
// CHIP-8 framebuffer reader: fetches BASE_ADDR..+255 over req/gnt and streams one pixel per valid/ready beat.
// First pixel 3 cycles after start (gnt=1); pix_ready low freezes the stream; SCREEN_SCANNER_SCALE2_EN gives 128x64 output.
module screen_scanner #(
    parameter int unsigned BASE_ADDR  = 'h100,
    parameter int          ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_data,
    output logic [6:0]            pix_x,
    output logic [5:0]            pix_y,
    output logic                  pix_last,
    output logic                  frame_done
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, DONE} state_t;

`ifdef SCREEN_SCANNER_SCALE2_EN
    localparam logic [6:0] XMAX   = 7'd127;
    localparam logic [5:0] YMAX   = 6'd63;
    localparam logic [9:0] NFETCH = 10'd512;
`else
    localparam logic [6:0] XMAX   = 7'd63;
    localparam logic [5:0] YMAX   = 6'd31;
    localparam logic [9:0] NFETCH = 10'd256;
`endif

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        pf_wait_q, pf_wait_d;
    logic [9:0]  fcnt_q, fcnt_d;
    logic [6:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic [7:0]  byte_off;
    logic        byte_end;
    logic        shift_step;
    logic        pf_req;
    logic        gnt_ok;
    logic        xfer;

    // fcnt counts fetches; in scaled mode bit 3 selects the repeat of a source row.
`ifdef SCREEN_SCANNER_SCALE2_EN
    assign byte_off   = {fcnt_q[8:4], fcnt_q[2:0]};
    assign byte_end   = (x_q[3:0] == 4'hf);
    assign shift_step = x_q[0];
`else
    assign byte_off   = fcnt_q[7:0];
    assign byte_end   = (x_q[2:0] == 3'h7);
    assign shift_step = 1'b1;
`endif

    assign pf_req     = (state_q == SHIFT) && !hold_vld_q && !pf_wait_q && (fcnt_q != NFETCH);
    assign mem_req    = (state_q == REQ) || pf_req;
    assign gnt_ok     = mem_req && mem_gnt;
    assign mem_addr   = mem_req ? (ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(byte_off)) : '0;

    assign pix_valid  = (state_q == SHIFT);
    assign pix_data   = shift_q[7];
    assign pix_x      = x_q;
    assign pix_y      = y_q;
    assign pix_last   = pix_valid && (x_q == XMAX) && (y_q == YMAX);
    assign xfer       = pix_valid && pix_ready;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        pf_wait_d    = 1'b0;
        fcnt_d       = fcnt_q;
        x_d          = x_q;
        y_d          = y_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        if (gnt_ok) fcnt_d = fcnt_q + 10'd1;
        if (frame_done_q) busy_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    state_d    = REQ;
                    fcnt_d     = '0;
                    x_d        = '0;
                    y_d        = '0;
                    hold_vld_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            REQ: begin
                if (mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                shift_d = mem_rdata;
                state_d = SHIFT;
            end
            SHIFT: begin
                pf_wait_d = gnt_ok;
                if (pf_wait_q) begin
                    hold_d     = mem_rdata;
                    hold_vld_d = 1'b1;
                end
                if (xfer) begin
                    if (shift_step) shift_d = {shift_q[6:0], 1'b0};
                    if (x_q == XMAX) begin
                        x_d = '0;
                        y_d = (y_q == YMAX) ? 6'd0 : y_q + 6'd1;
                    end else begin
                        x_d = x_q + 7'd1;
                    end
                    if (pix_last) begin
                        state_d = DONE;
                    end else if (byte_end) begin
                        // Prefetched data landing this very cycle bypasses hold to keep the stream gapless.
                        if (hold_vld_q) begin
                            shift_d    = hold_q;
                            hold_vld_d = 1'b0;
                        end else if (pf_wait_q) begin
                            shift_d    = mem_rdata;
                            hold_vld_d = 1'b0;
                        end else if (gnt_ok) begin
                            state_d   = WAIT;
                            pf_wait_d = 1'b0;
                        end else begin
                            state_d = REQ;
                        end
                    end
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            pf_wait_q    <= 1'b0;
            fcnt_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            pf_wait_q    <= pf_wait_d;
            fcnt_q       <= fcnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_screen_scanner.sv
// Bench for screen_scanner: frame vectors from a table, pixel scoreboard fed from a framebuffer model.
module tb_screen_scanner;

`ifdef SCREEN_SCANNER_SCALE2_EN
    localparam int W = 128, H = 64, NFETCH = 512, SC = 2;
`else
    localparam int W = 64, H = 32, NFETCH = 256, SC = 1;
`endif
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_gnt = 1'b1;
    logic        pix_ready = 1'b1;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy, mem_req, pix_valid, pix_data, pix_last, frame_done;
    logic [11:0] mem_addr;
    logic [6:0]  pix_x;
    logic [5:0]  pix_y;

    always #5 clk = ~clk;

    screen_scanner #(.BASE_ADDR('h100), .ADDR_WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [6:0] x;
        logic [5:0] y;
        logic       d;
        logic       l;
    } px_t;

    typedef struct {
        int         set_idx;
        logic [7:0] set_val;
        int         stall_at;
        int         gnt_low;
        int         px;
        int         py;
        logic       exp_d;
        logic       exp_l;
    } vec_t;

    px_t         exp_q[$];
    logic [11:0] addr_log[$];
    logic [7:0]  img[256];
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0;
    int          xfer_cnt = 0, proto_err = 0, gap_err = 0;
    int          done_cyc = 0, last_cyc = 0;
    logic        done_seen = 1'b0, busy_at_done = 1'b0;
    int          probe_x = -1, probe_y = -1;
    logic        probe_hit = 1'b0, probe_d = 1'b0, probe_l = 1'b0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: one-cycle read latency, plus request protocol checks.
    logic        pgnt = 1'b0, pend = 1'b0;
    logic [11:0] paddr = 12'h000;
    always @(posedge clk) begin
        if (!rst_n) begin
            pgnt <= 1'b0;
            pend <= 1'b0;
        end else begin
            if (mem_req && mem_gnt) begin
                if (mem_addr[11:8] != 4'h1) proto_err++;
                mem_rdata <= img[mem_addr[7:0]];
                addr_log.push_back(mem_addr);
            end
            if (pgnt && mem_req) proto_err++;
            if (pend && (!mem_req || mem_addr != paddr)) proto_err++;
            pgnt  <= mem_req && mem_gnt;
            pend  <= mem_req && !mem_gnt;
            paddr <= mem_addr;
        end
    end

    // Stream monitor: scoreboard pops, stall stability, gap tracking, frame_done timing.
    logic [15:0] held = '0;
    logic        prev_stall = 1'b0, in_frame = 1'b0;
    always @(negedge clk) begin
        px_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            in_frame   = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", {pix_valid, pix_data, pix_x, pix_y, pix_last}, held);
            if (in_frame && !pix_valid) gap_err++;
            if (pix_valid && pix_ready) begin
                xfer_cnt++;
                last_cyc = cyc;
                chk("pix_queue_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("pix", {pix_x, pix_y, pix_data, pix_last}, e);
                end
                if (int'(pix_x) == probe_x && int'(pix_y) == probe_y) begin
                    probe_hit = 1'b1;
                    probe_d   = pix_data;
                    probe_l   = pix_last;
                end
            end
            if (pix_valid) in_frame = !(pix_ready && pix_last);
            prev_stall = pix_valid && !pix_ready;
            held       = {pix_valid, pix_data, pix_x, pix_y, pix_last};
            if (frame_done) begin
                done_seen    = 1'b1;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
        end
    end

    task automatic load_frame(input int idx, input logic [7:0] val);
        int sx, sy;
        logic [7:0] b;
        px_t e;
        foreach (img[i]) img[i] = 8'h00;
        img[idx] = val;
        exp_q.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                sx  = x / SC;
                sy  = y / SC;
                b   = img[sy * 8 + sx / 8];
                e.x = 7'(x);
                e.y = 6'(y);
                e.d = b[7 - (sx % 8)];
                e.l = (x == W - 1) && (y == H - 1);
                exp_q.push_back(e);
            end
        end
        addr_log.delete();
        xfer_cnt  = 0;
        proto_err = 0;
        gap_err   = 0;
        done_seen = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int   k, c0, bad;
        logic vseen;
        load_frame(v.set_idx, v.set_val);
        probe_x   = v.px;
        probe_y   = v.py;
        probe_hit = 1'b0;
        mem_gnt   = (v.gnt_low == 0);
        @(posedge clk); #1 start = 1'b1; c0 = cyc;
        @(negedge clk);
        chk("busy_before_start", busy, 0);
        @(posedge clk); #1 start = 1'b0;
        k = 0; vseen = 1'b0; bad = 0;
        while (!vseen && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) chk("busy_after_start", busy, 1);
            if (k <= v.gnt_low && (!mem_req || mem_addr != 12'h100 || pix_valid)) bad++;
            if (pix_valid) vseen = 1'b1;
            else if (k == v.gnt_low) begin
                @(posedge clk); #1 mem_gnt = 1'b1;
            end
        end
        chk("gnt_low_hold", bad, 0);
        chk("first_valid_latency", k, v.gnt_low + 3);
        if (v.stall_at >= 0) begin
            k = 0;
            while (xfer_cnt < v.stall_at && k < 1000) begin
                @(negedge clk); #1; k++;
            end
            chk("stall_reached", xfer_cnt, v.stall_at);
            @(posedge clk); #1 pix_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 pix_ready = 1'b1;
        end
        k = 0;
        while (!done_seen && k < NPIX + 100) begin
            @(negedge clk); #1; k++;
            if (k == 100) begin
                @(posedge clk); #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        end
        chk("frame_done_seen", done_seen, 1);
        chk("busy_at_done", busy_at_done, 1);
        chk("done_after_last", done_cyc - last_cyc, 2);
        chk("xfer_count", xfer_cnt, NPIX);
        chk("queue_drained", exp_q.size(), 0);
        chk("probe_hit", probe_hit, 1);
        chk("probe_data", probe_d, v.exp_d);
        chk("probe_last", probe_l, v.exp_l);
        chk("gapless", gap_err, 0);
        if (v.stall_at < 0 && v.gnt_low == 0) chk("frame_cycles_le_npix_plus4", (done_cyc - c0) <= NPIX + 4, 1);
        bad = 0;
        for (int i = 0; i < addr_log.size(); i++)
            if (addr_log[i] != 12'(32'h100 + (i / (8 * SC)) * 8 + (i % 8))) bad++;
        chk("addr_count", addr_log.size(), NFETCH);
        chk("addr_seq", bad, 0);
        chk("mem_protocol", proto_err, 0);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_pulse_width", frame_done, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int k, bad;
`ifdef SCREEN_SCANNER_SCALE2_EN
        vecs.push_back('{0,   8'h80, -1, 0,  1,   1,  1'b1, 1'b0});
        vecs.push_back('{0,   8'h80, 20, 10, 2,   0,  1'b0, 1'b0});
        vecs.push_back('{0,   8'h80, -1, 0,  0,   2,  1'b0, 1'b0});
        vecs.push_back('{255, 8'h01, -1, 0,  127, 63, 1'b1, 1'b1});
        vecs.push_back('{255, 8'h01, 7,  0,  125, 63, 1'b0, 1'b0});
`else
        vecs.push_back('{0,   8'h80, -1, 0,  0,  0,  1'b1, 1'b0});
        vecs.push_back('{0,   8'h80, 11, 0,  1,  0,  1'b0, 1'b0});
        vecs.push_back('{255, 8'h01, -1, 10, 63, 31, 1'b1, 1'b1});
        vecs.push_back('{255, 8'h01, -1, 0,  62, 31, 1'b0, 1'b0});
        vecs.push_back('{9,   8'h20, 7,  0,  10, 1,  1'b1, 1'b0});
        vecs.push_back('{37,  8'hFF, -1, 0,  39, 4,  1'b0, 1'b0});
`endif
        foreach (img[i]) img[i] = 8'h00;
        #12;
        chk("reset_outputs", {mem_req, mem_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, frame_done}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Abandon a frame mid-stream with reset, then restart cleanly.
        load_frame(0, 8'h80);
        probe_x = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (xfer_cnt < 300 && k < 1000) begin
            @(negedge clk); #1; k++;
        end
        chk("reset_reach_300", xfer_cnt, 300);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", {mem_req, mem_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, frame_done}, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_done || busy || mem_req || pix_valid) bad++;
        end
        chk("post_reset_idle", bad, 0);
        run_frame(vecs[0]);
        chk("restart_first_addr", addr_log.size() > 0 ? addr_log[0] : 12'h000, 12'h100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/screen_scanner.md
Name: screen_scanner

Overview:
- Reader side of the CHIP-8 framebuffer. The CPU writes pixels into the 256-byte screen region at 0x100–0x1FF: 32 rows of 8 bytes, MSB is the leftmost pixel.
- This block fetches that region through a request/grant port on the shared memory and streams one pixel per handshake to the display driver.
- Holds a one-byte prefetch buffer so the stream has no gaps while memory grants promptly.

Parameters:
- BASE_ADDR, 12'h100, address of the top-left byte of the framebuffer.
- ADDR_WIDTH, 12, memory address width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: scan one frame. Ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until the cycle after frame_done.
- mem_req  out  1  read request to the arbiter.
- mem_gnt  in  1  grant; meaningful only while mem_req=1.
- mem_addr  out  ADDR_WIDTH  read address; stable while mem_req=1.
- mem_rdata  in  8  read data, valid exactly one cycle after a cycle with mem_req & mem_gnt.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  consumer accepts the pixel; a transfer is pix_valid & pix_ready.
- pix_data  out  1  pixel value.
- pix_x  out  7  output column.
- pix_y  out  6  output row.
- pix_last  out  1  marks the final pixel of the frame.
- frame_done  out  1  one-cycle pulse after the last transfer.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_last=0, busy=0, frame_done=0. State is IDLE and the prefetch buffer is empty.
- Reset is asynchronous. Asserting it mid-frame abandons the frame immediately: no frame_done, and any outstanding grant is ignored.
- States:
  - IDLE: on start, set byte index=0 and go to REQ.
  - REQ: mem_req=1, mem_addr=BASE_ADDR+index. Hold until mem_gnt=1, then go to WAIT.
  - WAIT: capture mem_rdata into the shift register, then go to SHIFT.
  - SHIFT: pix_valid=1 and pix_data=shift[7]. On each transfer, shift left and increment the pixel counter.
  - DONE: frame_done=1 for one cycle, then go to IDLE.
- Latency: with mem_gnt tied high, pix_valid first rises 3 cycles after the cycle in which start is sampled.
- Prefetch (in SHIFT only): if the hold register is empty and the byte being shifted is not the last byte of the frame, assert mem_req for the next address. After the grant, the next cycle captures mem_rdata into hold and sets hold_valid.
- Prefetch timing: the hold capture cycle may coincide with a pixel transfer; both take effect.
- When the 8th pixel of a byte transfers:
  - hold_valid=1: load shift from hold, clear hold_valid, stay in SHIFT with no bubble cycle.
  - Otherwise, if bytes remain: go to REQ for the next index, or stay in the pending prefetch request if one is already asserted.
  - Last byte done: go to DONE.
- Stream rules: pix_data, pix_x, pix_y and pix_last stay stable while pix_valid=1 and pix_ready=0. pix_valid never drops without a transfer.
- Coordinates: pix_x = column 0..63 and pix_y = row 0..31; the unused MSBs are 0. Byte index = pix_y*8 + pix_x/8.
- pix_last=1 only with pix_x=63, pix_y=31.
- mem_req deasserts the cycle after a grant. There is only ever one outstanding read.

Optional Feature:
- Macro: SCREEN_SCANNER_SCALE2_EN.
- With the macro defined: output is 128x64.
  - Each source pixel is emitted on two consecutive transfers with the same pix_data. pix_x counts 0..127 and pix_y 0..63.
  - Each source row is fetched twice, on output rows 2r and 2r+1, so the same 8 addresses repeat.
  - A frame is 8192 pixels; pix_last is at (127,63).
- Without the macro: 64x32 as above, and the scale logic is absent.

Test Plan:
- Native frame, mem[0x100]=0x80 and the rest of the framebuffer 0, gnt=1, ready=1: first transfer is (0,0) with data=1; the next 7 transfers have data=0; exactly 2048 transfers; frame_done 2 cycles after the last transfer.
- mem[0x1FF]=0x01: the transfer at (63,31) has data=1 and pix_last=1; the transfer at (62,31) has data=0 and pix_last=0.
- pix_ready held low 5 cycles mid-byte: pix_valid stays 1 and pix_data/pix_x/pix_y do not change; the stream resumes with no lost or duplicated pixel.
- mem_gnt held low 10 cycles on the first request: mem_req=1 and mem_addr=0x100 held throughout; pix_valid=0 throughout; first pixel valid 2 cycles after the grant.
- Gapless check, gnt=1, ready=1: start to frame_done takes at most 2048+4 cycles, and pix_valid never drops mid-frame.
- Reset pulse at pixel 300 and then start again: all outputs return to reset values; the new frame begins at (0,0) with address 0x100.
- Scale feature defined: 8192 transfers; the mem_addr sequence shows each row's 8 addresses twice; mem[0x100]=0x80 gives data=1 at (0,0), (1,0), (0,1) and (1,1) only.
